// File: rtl/mux_select_scanner_pkg.sv
// Shared constants for the mux select scanner: state encodings and select geometry.
package mux_select_scanner_pkg;

  localparam int unsigned SEL_W      = 2;
  localparam int unsigned NUM_INPUTS = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  // Last select position; a tick here closes a sweep.
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_INPUTS - 1);

endpackage

// File: rtl/mux_select_scanner_rate_divider.sv
// Rate divider: free-running counter that strobes tick every DIV_MAX+1 cycles while run is high.
module mux_select_scanner_rate_divider #(
  parameter int unsigned DIV_WIDTH = 26,
  parameter int unsigned DIV_MAX   = 49999999
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] count;

  // A clear in the terminal cycle wins, so no step is taken then.
  assign tick = run && !clear && (count == TERM);

  // Count while running; clear, stop or terminal count returns to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (!run || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mux_select_scanner.sv
// Mux select scanner: steps a 2-bit select through 0..3 at a divided rate and
// assembles a snapshot of the mux data inputs from the sampled mux output.
module mux_select_scanner
  import mux_select_scanner_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 26,
  parameter int unsigned DIV_MAX   = 49999999
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  load,
  input  logic [SEL_W-1:0]      load_sel,
  input  logic                  mux_out,
  output logic [SEL_W-1:0]      sel,
  output logic                  tick,
  output logic [NUM_INPUTS-1:0] capture,
  output logic                  capture_valid
);

  logic [0:0] state;
  logic [0:0] state_next;
  logic       run;

  // Position 3 is never stored: its sample comes straight from mux_out at sweep end.
  logic [NUM_INPUTS-2:0] shadow;
  logic [NUM_INPUTS-2:0] seen;

  assign run = (state == S_SCAN);

  mux_select_scanner_rate_divider #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_MAX   (DIV_MAX)
  ) u_rate_divider (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .clear  (load),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable level selects between idle and scanning.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (enable)  state_next = S_SCAN;
      S_SCAN:  if (!enable) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Select stepping, per-position sampling and sweep capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel           <= '0;
      shadow        <= '0;
      seen          <= '0;
      capture       <= '0;
      capture_valid <= 1'b0;
    end else begin
      capture_valid <= 1'b0;
      if (load) begin
        sel    <= load_sel;
        shadow <= '0;
        seen   <= '0;
      end else if (tick) begin
        sel <= sel + SEL_W'(1);
        if (sel == SEL_LAST) begin
          seen <= '0;
          if (&seen) begin
            capture       <= {mux_out, shadow};
            capture_valid <= 1'b1;
          end
        end else begin
          shadow[sel] <= mux_out;
          seen[sel]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_select_scanner.sv
// Bench for mux_select_scanner: a DIV_MAX=3 instance (a) and a DIV_MAX=0 instance (b)
// share control inputs; each drives its own bench-side 4-to-1 mux.
module tb_mux_select_scanner;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic       load;
  logic [1:0] load_sel;
  logic [3:0] data_a, data_b;
  logic       mux_a, mux_b;
  logic [1:0] sel_a, sel_b;
  logic       tick_a, tick_b;
  logic [3:0] cap_a, cap_b;
  logic       cv_a, cv_b;
  logic [7:0] got_a, got_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = instance a, 1 = instance b.
  bit         m_scan[2];
  int         m_cnt[2];
  int         m_sel[2];
  int         m_seen[2];
  int         m_samp[2];
  logic [3:0] m_cap[2];
  bit         m_cv[2];

  assign mux_a = data_a[sel_a];
  assign mux_b = data_b[sel_b];
  assign got_a = {sel_a, tick_a, cap_a, cv_a};
  assign got_b = {sel_b, tick_b, cap_b, cv_b};

  mux_select_scanner #(.DIV_WIDTH(4), .DIV_MAX(3)) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .load(load), .load_sel(load_sel),
    .mux_out(mux_a), .sel(sel_a), .tick(tick_a), .capture(cap_a), .capture_valid(cv_a)
  );

  mux_select_scanner #(.DIV_WIDTH(2), .DIV_MAX(0)) dut_b (
    .clk(clk), .resetn(resetn), .enable(enable), .load(load), .load_sel(load_sel),
    .mux_out(mux_b), .sel(sel_b), .tick(tick_b), .capture(cap_b), .capture_valid(cv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dmax(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  // Expected {sel, tick, capture, capture_valid} for instance k right now.
  function automatic logic [7:0] expv(input int k);
    logic tk;
    tk = m_scan[k] && (m_cnt[k] == dmax(k)) && !load;
    return {2'(m_sel[k]), tk, m_cap[k], m_cv[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_scan[k] = 1'b0; m_cnt[k] = 0; m_sel[k] = 0; m_seen[k] = 0;
      m_samp[k] = 0; m_cap[k] = 4'h0; m_cv[k] = 1'b0;
    end
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_update();
    int d;
    int mx;
    bit tk;
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_scan[k] = 1'b0; m_cnt[k] = 0; m_sel[k] = 0; m_seen[k] = 0;
        m_samp[k] = 0; m_cap[k] = 4'h0; m_cv[k] = 1'b0;
      end else begin
        d  = (k == 0) ? int'(data_a) : int'(data_b);
        tk = m_scan[k] && (m_cnt[k] == dmax(k)) && !load;
        m_cv[k] = 1'b0;
        if (load) begin
          m_sel[k] = int'(load_sel); m_seen[k] = 0; m_samp[k] = 0; m_cnt[k] = 0;
        end else if (tk) begin
          mx = (d >> m_sel[k]) & 1;
          if (m_sel[k] == 3) begin
            if (m_seen[k] == 7) begin
              m_cap[k] = 4'(m_samp[k] | (mx << 3));
              m_cv[k]  = 1'b1;
            end
            m_seen[k] = 0;
          end else begin
            m_samp[k] = (m_samp[k] & ~(1 << m_sel[k])) | (mx << m_sel[k]);
            m_seen[k] = m_seen[k] | (1 << m_sel[k]);
          end
          m_sel[k] = (m_sel[k] + 1) % 4;
          m_cnt[k] = 0;
        end else if (m_scan[k]) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        if (!m_scan[k] || !enable) m_cnt[k] = 0;
        m_scan[k] = enable;
      end
    end
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    resetn = 1'b0; enable = 1'b0; load = 1'b0; load_sel = 2'd0;
    model_reset();
    advance();
    advance();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; load = 1'b0; resetn = 1'b0;
    data_a = 4'($urandom); data_b = 4'($urandom);
    model_reset();
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (got_a !== 8'h00 || got_b !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got a=%h b=%h expected 00 00", s, got_a, got_b);
      end
      advance();
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (got_a !== 8'h00 || got_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got a=%h b=%h expected 00 00", got_a, got_b);
    end
  endtask

  task automatic test_full_sweep();
    int ntick;
    int ncv;
    int cv_step;
    apply_reset();
    data_a = 4'b1101; data_b = 4'($urandom);
    enable = 1'b1;
    ntick = 0; ncv = 0; cv_step = -1;
    for (int s = 1; s <= 20; s++) begin
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL sweep_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      if (tick_a) begin
        checks++;
        if (sel_a !== 2'(ntick % 4)) begin
          errors++;
          $display("FAIL sweep_sel tick %0d: got %0d expected %0d", ntick, sel_a, ntick % 4);
        end
        ntick++;
      end
      if (cv_a) begin ncv++; cv_step = s; end
      advance();
    end
    #1;
    checks++;
    if (ntick !== 4) begin errors++; $display("FAIL sweep_ticks: got %0d expected 4", ntick); end
    checks++;
    if (ncv !== 1 || cv_step !== 18) begin
      errors++;
      $display("FAIL sweep_valid: got %0d pulses at step %0d expected 1 at 18", ncv, cv_step);
    end
    checks++;
    if (cap_a !== 4'b1101) begin errors++; $display("FAIL sweep_capture: got %b expected 1101", cap_a); end
    checks++;
    if (sel_a !== 2'd0) begin errors++; $display("FAIL sweep_wrap: got %0d expected 0", sel_a); end
  endtask

  task automatic test_stop_resume();
    int first;
    apply_reset();
    data_a = 4'($urandom); data_b = 4'($urandom);
    enable = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL stop_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      advance();
    end
    enable = 1'b0;
    for (int s = 0; s < 10; s++) begin
      #1;
      checks++;
      if (tick_a !== 1'b0 || sel_a !== 2'd2 || cv_a !== 1'b0) begin
        errors++;
        $display("FAIL stop_hold cyc %0d: got tick=%b sel=%0d valid=%b expected 0 2 0", s, tick_a, sel_a, cv_a);
      end
      advance();
    end
    enable = 1'b1;
    first = -1;
    for (int s = 1; s <= 16; s++) begin
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL resume_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      if (tick_a && first < 0) begin
        first = s;
        checks++;
        if (sel_a !== 2'd2) begin errors++; $display("FAIL resume_sel: got %0d expected 2", sel_a); end
      end
      advance();
    end
    checks++;
    if (first !== 5) begin errors++; $display("FAIL resume_latency: got %0d expected 5", first); end
  endtask

  task automatic test_load_collision();
    int first_tick;
    int first_sel;
    int first_cv;
    apply_reset();
    data_a = 4'($urandom); data_b = 4'($urandom);
    enable = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL load_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      advance();
    end
    load = 1'b1; load_sel = 2'b01;
    #1;
    checks++;
    if (tick_a !== 1'b0) begin errors++; $display("FAIL load_tick_masked: got %b expected 0", tick_a); end
    advance();
    load = 1'b0;
    #1;
    checks++;
    if (sel_a !== 2'd1 || sel_b !== 2'd1) begin
      errors++;
      $display("FAIL load_sel: got a=%0d b=%0d expected 1 1", sel_a, sel_b);
    end
    first_tick = -1; first_sel = -1; first_cv = -1;
    for (int s = 6; s <= 40; s++) begin
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL load_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      if (tick_a && first_tick < 0) begin first_tick = s; first_sel = int'(sel_a); end
      if (cv_a && first_cv < 0) first_cv = s;
      advance();
    end
    checks++;
    if (first_tick !== 9 || first_sel !== 1) begin
      errors++;
      $display("FAIL load_next_tick: got step %0d sel %0d expected step 9 sel 1", first_tick, first_sel);
    end
    checks++;
    if (first_cv !== 34) begin errors++; $display("FAIL load_first_valid: got step %0d expected 34", first_cv); end
  endtask

  task automatic test_div0();
    apply_reset();
    data_a = 4'($urandom); data_b = 4'b0110;
    enable = 1'b1;
    for (int s = 1; s <= 14; s++) begin
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL div0_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      if (s >= 2) begin
        checks++;
        if (tick_b !== 1'b1 || sel_b !== 2'((s - 2) % 4)) begin
          errors++;
          $display("FAIL div0_step step %0d: got tick=%b sel=%0d expected 1 %0d", s, tick_b, sel_b, (s - 2) % 4);
        end
      end
      checks++;
      if (cv_b !== ((s >= 6) && ((s - 6) % 4 == 0))) begin
        errors++;
        $display("FAIL div0_valid step %0d: got %b", s, cv_b);
      end
      if (s >= 6) begin
        checks++;
        if (cap_b !== 4'b0110) begin errors++; $display("FAIL div0_capture step %0d: got %b expected 0110", s, cap_b); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    data_a = 4'($urandom); data_b = 4'($urandom);
    enable = 1'b1;
    for (int s = 1; s <= 16; s++) begin
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL midrst_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      advance();
    end
    #1;
    checks++;
    if (sel_a !== 2'd3 || tick_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pending: got sel=%0d tick=%b expected 3 1", sel_a, tick_a);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (got_a !== 8'h00 || got_b !== 8'h00) begin
      errors++;
      $display("FAIL midrst_immediate: got a=%h b=%h expected 00 00", got_a, got_b);
    end
    model_reset();
    advance();
    resetn = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++;
      if (cv_a !== 1'b0 || {got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL midrst_after cyc %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      advance();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int s = 0; s < 600; s++) begin
      enable   = ($urandom_range(9) != 0);
      load     = ($urandom_range(19) == 0);
      load_sel = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) data_a = 4'($urandom);
      if ($urandom_range(7) == 0) data_b = 4'($urandom);
      resetn   = ($urandom_range(149) != 0);
      if (!resetn) model_reset();
      #1;
      checks++;
      if ({got_a, got_b} !== {expv(0), expv(1)}) begin
        errors++;
        $display("FAIL random_model step %0d: got %h expected %h", s, {got_a, got_b}, {expv(0), expv(1)});
      end
      advance();
    end
    resetn = 1'b1;
    load   = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; enable = 1'b0; load = 1'b0; load_sel = 2'd0;
    data_a = 4'h0; data_b = 4'h0;
    model_reset();
    #1 resetn = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_sweep();
    test_stop_resume();
    test_load_collision();
    test_div0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
